// File: rtl/tft_frame_monitor.sv
// Receive-side TFT pixel-stream monitor: recovers frame and line framing from den alone.
// Reports geometry, line period, an RGB checksum and a probed pixel once per completed frame.
module tft_frame_monitor #(
    parameter int H_ACT    = 800,
    parameter int V_ACT    = 480,
    parameter int H_TOTAL  = 1056,
    parameter int VGAP_MIN = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        den,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic [10:0] probe_x,
    input  logic [9:0]  probe_y,
    input  logic        probe_load,
    output logic        frame_valid,
    output logic [10:0] width,
    output logic [9:0]  height,
    output logic [10:0] line_period,
    output logic [23:0] checksum,
    output logic [23:0] probe_rgb,
    output logic        probe_hit,
    output logic        err_width,
    output logic        err_height,
    output logic        err_period,
    output logic        locked,
    output logic [15:0] frame_count
);
    localparam int            GW      = $clog2(VGAP_MIN + 1);
    localparam logic [GW-1:0] GAP_END = GW'(VGAP_MIN);
    localparam logic [10:0]   X_EXP   = 11'(H_ACT);
    localparam logic [10:0]   P_EXP   = 11'(H_TOTAL);
    localparam logic [10:0]   X_MAX   = 11'h7FF;
    localparam logic [9:0]    Y_EXP   = 10'(V_ACT);
    localparam logic [9:0]    Y_MAX   = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, VBLANK, LINE, HBLANK} state_t;
    state_t state, state_nxt;

    logic [GW-1:0] gap, gap_inc;
    logic [10:0]   x_cnt, prd_cnt, prd_last, last_w;
    logic [9:0]    y_cnt;
    logic [23:0]   sum_acc, cap_rgb, pix;
    logic [10:0]   shd_x, act_x, nxt_x, tgt_x, pix_col;
    logic [9:0]    shd_y, act_y, nxt_y, tgt_y, pix_row;
    logic          hit_acc, err_w_acc, err_p_acc;
    logic          gap_full, frame_start, frame_end, line_rise, line_fall, pix_cap;

    assign pix      = {r, g, b};
    assign gap_full = (gap == GAP_END);
    assign gap_inc  = gap_full ? gap : gap + 1'b1;

    // A den rise landing on the same edge that completes the vertical gap both ends the old frame and starts a new one.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_rise   = 1'b0;
        line_fall   = 1'b0;
        case (state)
            SEARCH: if (gap_full) begin
                if (den) begin
                    frame_start = 1'b1;
                    state_nxt   = LINE;
                end else begin
                    state_nxt   = VBLANK;
                end
            end
            VBLANK: if (den) begin
                frame_start = 1'b1;
                state_nxt   = LINE;
            end
            LINE: if (!den) begin
                line_fall = 1'b1;
                state_nxt = HBLANK;
            end
            HBLANK: if (gap_full) begin
                frame_end = 1'b1;
                if (den) begin
                    frame_start = 1'b1;
                    state_nxt   = LINE;
                end else begin
                    state_nxt   = VBLANK;
                end
            end else if (den) begin
                line_rise = 1'b1;
                state_nxt = LINE;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_nxt;
    end

    // Probe target switches to the shadow (or a same-edge load) only on the frame's first pixel.
    assign nxt_x   = probe_load ? probe_x : shd_x;
    assign nxt_y   = probe_load ? probe_y : shd_y;
    assign tgt_x   = frame_start ? nxt_x : act_x;
    assign tgt_y   = frame_start ? nxt_y : act_y;
    assign pix_col = (state == LINE) ? x_cnt : 11'd0;
    assign pix_row = frame_start ? 10'd0 : y_cnt;
    assign pix_cap = (frame_start | line_rise | ((state == LINE) & den))
                     & (pix_col == tgt_x) & (pix_row == tgt_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap         <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            prd_cnt     <= '0;
            prd_last    <= '0;
            last_w      <= '0;
            sum_acc     <= '0;
            cap_rgb     <= '0;
            shd_x       <= '0;
            shd_y       <= '0;
            act_x       <= '0;
            act_y       <= '0;
            hit_acc     <= 1'b0;
            err_w_acc   <= 1'b0;
            err_p_acc   <= 1'b0;
            frame_valid <= 1'b0;
            width       <= '0;
            height      <= '0;
            line_period <= '0;
            checksum    <= '0;
            probe_rgb   <= '0;
            probe_hit   <= 1'b0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            err_period  <= 1'b0;
            locked      <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (probe_load) begin
                shd_x <= probe_x;
                shd_y <= probe_y;
            end

            case (state)
                SEARCH:  gap <= den ? '0 : gap_inc;
                LINE:    if (!den) gap <= GW'(1);
                HBLANK:  if (!den) gap <= gap_inc;
                default: ;
            endcase

            if (frame_start || line_rise)
                prd_cnt <= 11'd1;
            else if ((state == LINE || state == HBLANK) && prd_cnt != X_MAX)
                prd_cnt <= prd_cnt + 11'd1;

            if (frame_start) begin
                x_cnt     <= 11'd1;
                y_cnt     <= '0;
                sum_acc   <= pix;
                act_x     <= nxt_x;
                act_y     <= nxt_y;
                hit_acc   <= pix_cap;
                cap_rgb   <= pix_cap ? pix : 24'd0;
                err_w_acc <= 1'b0;
                err_p_acc <= 1'b0;
                prd_last  <= '0;
            end else begin
                if (line_rise) begin
                    prd_last <= prd_cnt;
                    if (prd_cnt != P_EXP || prd_cnt == X_MAX) err_p_acc <= 1'b1;
                    x_cnt   <= 11'd1;
                    sum_acc <= sum_acc + pix;
                end
                if (state == LINE && den) begin
                    if (x_cnt != X_MAX) x_cnt <= x_cnt + 11'd1;
                    sum_acc <= sum_acc + pix;
                end
                if (line_fall) begin
                    last_w <= x_cnt;
                    if (x_cnt != X_EXP || x_cnt == X_MAX) err_w_acc <= 1'b1;
                    if (y_cnt != Y_MAX) y_cnt <= y_cnt + 10'd1;
                end
                if (pix_cap) begin
                    hit_acc <= 1'b1;
                    cap_rgb <= pix;
                end
            end

            if (frame_end) begin
                frame_valid <= 1'b1;
                width       <= last_w;
                height      <= y_cnt;
                line_period <= prd_last;
                checksum    <= sum_acc;
                probe_rgb   <= hit_acc ? cap_rgb : 24'd0;
                probe_hit   <= hit_acc;
                err_width   <= err_w_acc;
                err_height  <= (y_cnt != Y_EXP) || (y_cnt == Y_MAX);
                err_period  <= err_p_acc;
                locked      <= !(err_w_acc || err_p_acc || (y_cnt != Y_EXP) || (y_cnt == Y_MAX));
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tft_frame_monitor.sv
// Scoreboard bench for tft_frame_monitor with reduced timing (8x5 active, 12-cycle lines, 20-cycle vgap).
// Frames are described as line widths and gaps; expected results are derived from that description.
module tb_tft_frame_monitor;
    localparam int HA = 8, VA = 5, HT = 12, VG = 20;

    logic        clk = 1'b0, rst = 1'b1, den = 1'b0, probe_load = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [10:0] probe_x = '0;
    logic [9:0]  probe_y = '0;
    logic        frame_valid, probe_hit, err_width, err_height, err_period, locked;
    logic [10:0] width, line_period;
    logic [9:0]  height;
    logic [23:0] checksum, probe_rgb;
    logic [15:0] frame_count;

    tft_frame_monitor #(.H_ACT(HA), .V_ACT(VA), .H_TOTAL(HT), .VGAP_MIN(VG)) dut (
        .clk(clk), .rst(rst), .den(den), .r(r), .g(g), .b(b),
        .probe_x(probe_x), .probe_y(probe_y), .probe_load(probe_load),
        .frame_valid(frame_valid), .width(width), .height(height), .line_period(line_period),
        .checksum(checksum), .probe_rgb(probe_rgb), .probe_hit(probe_hit),
        .err_width(err_width), .err_height(err_height), .err_period(err_period),
        .locked(locked), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          w, h, lp, at;
        logic [23:0] cs, prgb;
        bit          hit, ew, eh, ep, lk;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    exp_t e, last;
    bit   have_last = 0;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per frame_valid pulse; between pulses results must hold.
    always @(negedge clk) begin
        if (rst) begin
            have_last = 0;
        end else if (frame_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.at);
                chk("width", 32'(width), e.w);
                chk("height", 32'(height), e.h);
                chk("line_period", 32'(line_period), e.lp);
                chk("checksum", checksum, e.cs);
                chk("probe_hit", probe_hit, e.hit);
                chk("probe_rgb", probe_rgb, e.prgb);
                chk("err_width", err_width, e.ew);
                chk("err_height", err_height, e.eh);
                chk("err_period", err_period, e.ep);
                chk("locked", locked, e.lk);
                chk("frame_count", frame_count, e.fc);
                last = e;
                have_last = 1;
            end
        end else if (have_last) begin
            chk("hold_checksum", checksum, last.cs);
            chk("hold_frame_count", frame_count, last.fc);
        end
    end

    // Frame description and reference-model state
    int          lw[16], lg[16];
    int          pmode, spx, spy, pl_line, pl_x, pl_y, rst_line;
    logic [23:0] cval;
    int          sh_x = 0, sh_y = 0;
    logic [15:0] mfc = 0;

    function automatic logic [23:0] pixel(input int x, input int y);
        case (pmode)
            0:       return cval;
            1:       return 24'($urandom);
            default: return (x == spx && y == spy) ? cval : 24'd0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            den = 1'b0;
            probe_load = 1'b0;
            {r, g, b} = 24'($urandom);
            probe_x = 11'($urandom_range(0, 2047));
            probe_y = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic reset_checks();
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_width", 32'(width), 0);
        chk("rst_height", 32'(height), 0);
        chk("rst_line_period", 32'(line_period), 0);
        chk("rst_probe", {probe_hit, probe_rgb}, 0);
        chk("rst_errs", {err_width, err_height, err_period}, 0);
        chk("rst_locked", locked, 0);
    endtask

    task automatic load_probe(input int x, input int y);
        @(negedge clk);
        den = 1'b0;
        probe_load = 1'b1;
        probe_x = 11'(x);
        probe_y = 10'(y);
        sh_x = x;
        sh_y = y;
        idle(1);
    endtask

    task automatic set_clean(input int n);
        for (int i = 0; i < n; i++) begin
            lw[i] = HA;
            lg[i] = HT - HA;
        end
        lg[n-1] = VG + 3 + $urandom_range(0, 6);
    endtask

    task automatic run_frame(input int n, input bit report);
        int ax = 0, ay = 0, last_edge = 0;
        bit hit = 0, ew = 0, ep = 0;
        logic [23:0] sum = '0, prgb = '0, pix;
        exp_t x_e;
        for (int l = 0; l < n; l++) begin
            for (int x = 0; x < lw[l]; x++) begin
                @(negedge clk);
                probe_load = 1'b0;
                if (x == 0 && l == pl_line) begin
                    probe_load = 1'b1;
                    probe_x = 11'(pl_x);
                    probe_y = 10'(pl_y);
                    sh_x = pl_x;
                    sh_y = pl_y;
                end
                if (l == 0 && x == 0) begin
                    ax = sh_x;
                    ay = sh_y;
                end
                pix = pixel(x, l);
                den = 1'b1;
                {r, g, b} = pix;
                sum += pix;
                if (x == ax && l == ay) begin
                    hit = 1;
                    prgb = pix;
                end
                last_edge = cyc + 1;
            end
            if (lw[l] != HA) ew = 1;
            if (l < n - 1 && lw[l] + lg[l] != HT) ep = 1;
            if (l == n - 1 && report) begin
                mfc++;
                x_e.w = lw[n-1];
                x_e.h = n;
                x_e.lp = (n >= 2) ? lw[n-2] + lg[n-2] : 0;
                x_e.at = last_edge + VG + 1;
                x_e.cs = sum;
                x_e.hit = hit;
                x_e.prgb = hit ? prgb : 24'd0;
                x_e.ew = ew;
                x_e.eh = (n != VA);
                x_e.ep = ep;
                x_e.lk = !(ew || ep || n != VA);
                x_e.fc = mfc;
                q.push_back(x_e);
            end
            if (l == rst_line) begin
                idle(1);
                rst = 1'b1;
                sh_x = 0;
                sh_y = 0;
                mfc = 0;
                #1 reset_checks();
                idle(3);
                @(negedge clk);
                rst = 1'b0;
                idle(lg[l] - 5);
            end else begin
                idle(lg[l]);
            end
        end
        pl_line = -1;
        rst_line = -1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending frames", q.size());
            q.delete();
        end
    endtask

    initial begin
        pl_line = -1;
        rst_line = -1;
        pmode = 0;
        cval = 24'h00FF00;
        repeat (3) @(negedge clk);
        #1 reset_checks();
        @(negedge clk);
        rst = 1'b0;

        // Stream joins mid-frame: partial frame is not reported, then two clean green frames
        set_clean(3);
        run_frame(3, 0);
        set_clean(VA);
        run_frame(VA, 1);
        set_clean(VA);
        run_frame(VA, 1);

        // Single probed pixel on an otherwise black frame
        load_probe(5, 3);
        pmode = 2; spx = 5; spy = 3; cval = 24'h123456;
        set_clean(VA);
        run_frame(VA, 1);

        // One short line (period kept nominal), then a clean frame
        pmode = 1;
        set_clean(VA);
        lw[2] = HA - 1;
        lg[2] = HT - HA + 1;
        run_frame(VA, 1);
        set_clean(VA);
        run_frame(VA, 1);

        // Missing line, then one long line interval
        set_clean(VA - 1);
        run_frame(VA - 1, 1);
        set_clean(VA);
        lg[1] = HT - HA + 1;
        run_frame(VA, 1);

        // Mid-frame probe load affects only the next frame; same-edge load applies immediately
        pl_line = 2; pl_x = 900; pl_y = 0;
        set_clean(VA);
        run_frame(VA, 1);
        set_clean(VA);
        run_frame(VA, 1);
        pl_line = 0; pl_x = 2; pl_y = 1;
        set_clean(VA);
        run_frame(VA, 1);
        drain();

        // Reset in the middle of a frame; the remainder is discarded, next full frame is count 1
        set_clean(VA);
        lg[1] = 8;
        rst_line = 1;
        run_frame(VA, 0);
        set_clean(VA);
        run_frame(VA, 1);

        // Randomised geometry, gaps (including a gap of exactly VG) and probe loads
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(VA - 1, VA + 1);
            for (int i = 0; i < n; i++) begin
                lw[i] = HA - 1 + $urandom_range(0, 2);
                lg[i] = ($urandom_range(0, 1) == 1) ? HT - lw[i] : $urandom_range(1, VG - 1);
            end
            lg[n-1] = VG + $urandom_range(0, 4);
            pl_line = $urandom_range(0, n);
            pl_x = $urandom_range(0, 9);
            pl_y = $urandom_range(0, 6);
            run_frame(n, 1);
        end
        idle(VG + 5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
